// File: rtl/slave_2k_serial.sv
// slave_2k_serial: non-split serial bus slave with 2**ADDR_W bytes of byte-wide storage.
// Deserialises address/write data from B_BUS_OUT, serialises read data onto B_BUS_IN.
// Optional build macro SLAVE_PARITY_EN: adds an even-parity bit after every data byte
// in both directions, plus the S_PERR output that flags a rejected write.
module slave_2k_serial #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned RD_LAT = 2
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       AD_SEL,
  input  logic       A_ADD,
  input  logic       B_BUS_OUT,
  input  logic       B_RW,
  output logic       B_ACK,
  output logic       B_READY,
  output logic       B_BUS_IN,
  output logic       B_SBSY,
  output logic       S_DVALID,
  output logic [7:0] S_DOUT
`ifdef SLAVE_PARITY_EN
  ,
  output logic       S_PERR
`endif
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam int unsigned CNT_W      = ($clog2(ADDR_W + 1) > 4) ? $clog2(ADDR_W + 1) : 4;
`ifdef SLAVE_PARITY_EN
  localparam int unsigned FRAME_W    = 9;
`else
  localparam int unsigned FRAME_W    = 8;
`endif
  localparam int unsigned LAST_BIT   = FRAME_W - 1;
  localparam int unsigned IDX_W      = $clog2(FRAME_W);
  localparam int unsigned RWAIT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                rw;
  logic                rw_nxt;
  logic [7:0]          shreg;
  logic [7:0]          shreg_nxt;
  logic                ack_nxt;
  logic                ready_nxt;
  logic                bus_in_nxt;
  logic                dvalid_nxt;
  logic                sbsy_nxt;
  logic [7:0]          dout_nxt;
  logic                mem_we;
  logic [7:0]          mem [DEPTH];
  logic [7:0]          rd_byte;
  logic [FRAME_W-1:0]  rd_frame;
  logic                addr_done;
  logic                data_last;
`ifdef SLAVE_PARITY_EN
  logic                perr_nxt;
`endif

  assign rd_byte   = mem[addr];
  assign addr_done = (cnt == CNT_W'(ADDR_W));
  assign data_last = (cnt == CNT_W'(LAST_BIT));

  // Serial read frame: data LSB first, then the even-parity bit when enabled.
`ifdef SLAVE_PARITY_EN
  assign rd_frame = {^shreg, shreg};
`else
  assign rd_frame = shreg;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; losing AD_SEL always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (AD_SEL && A_ADD) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (!AD_SEL)        state_nxt = ST_IDLE;
        else if (addr_done) state_nxt = rw ? ST_WDATA : ((RD_LAT == 0) ? ST_RDATA : ST_RWAIT);
        else if (!A_ADD)    state_nxt = ST_IDLE;
      end
      ST_WDATA: begin
        if (!AD_SEL || data_last) state_nxt = ST_IDLE;
      end
      ST_RWAIT: begin
        if (!AD_SEL)                              state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(RWAIT_LAST))       state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        if (!AD_SEL || data_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything below is registered on the next edge.
  always_comb begin
    ack_nxt    = 1'b0;
    ready_nxt  = 1'b0;
    bus_in_nxt = 1'b0;
    dvalid_nxt = 1'b0;
    dout_nxt   = S_DOUT;
    mem_we     = 1'b0;
    cnt_nxt    = cnt;
    addr_nxt   = addr;
    rw_nxt     = rw;
    shreg_nxt  = shreg;
    sbsy_nxt   = (state_nxt != ST_IDLE);
`ifdef SLAVE_PARITY_EN
    perr_nxt   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (AD_SEL && A_ADD) begin
          addr_nxt = {B_BUS_OUT, addr[ADDR_W-1:1]};
          cnt_nxt  = CNT_W'(1);
          rw_nxt   = B_RW;
        end
      end
      ST_ADDR: begin
        if (AD_SEL) begin
          if (addr_done) begin
            cnt_nxt = '0;
            if (!rw && (RD_LAT == 0)) begin
              shreg_nxt  = rd_byte;
              ready_nxt  = 1'b1;
              bus_in_nxt = rd_byte[0];
            end
          end else if (A_ADD) begin
            addr_nxt = {B_BUS_OUT, addr[ADDR_W-1:1]};
            cnt_nxt  = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ADDR_W - 1)) ack_nxt = 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (AD_SEL) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt < CNT_W'(8)) shreg_nxt = {B_BUS_OUT, shreg[7:1]};
          if (data_last) begin
`ifdef SLAVE_PARITY_EN
            if ((^shreg) == B_BUS_OUT) begin
              mem_we     = 1'b1;
              ready_nxt  = 1'b1;
              dvalid_nxt = 1'b1;
              dout_nxt   = shreg;
            end else begin
              perr_nxt   = 1'b1;
            end
`else
            mem_we     = 1'b1;
            ready_nxt  = 1'b1;
            dvalid_nxt = 1'b1;
            dout_nxt   = shreg_nxt;
`endif
          end
        end
      end
      ST_RWAIT: begin
        if (AD_SEL) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(RWAIT_LAST)) begin
            cnt_nxt    = '0;
            shreg_nxt  = rd_byte;
            ready_nxt  = 1'b1;
            bus_in_nxt = rd_byte[0];
          end
        end
      end
      ST_RDATA: begin
        if (AD_SEL) begin
          if (data_last) begin
            dvalid_nxt = 1'b1;
            dout_nxt   = shreg;
          end else begin
            cnt_nxt    = cnt + CNT_W'(1);
            ready_nxt  = 1'b1;
            bus_in_nxt = rd_frame[IDX_W'(cnt + CNT_W'(1))];
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt      <= '0;
      addr     <= '0;
      rw       <= 1'b0;
      shreg    <= '0;
      B_ACK    <= 1'b0;
      B_READY  <= 1'b0;
      B_BUS_IN <= 1'b0;
      B_SBSY   <= 1'b0;
      S_DVALID <= 1'b0;
      S_DOUT   <= '0;
`ifdef SLAVE_PARITY_EN
      S_PERR   <= 1'b0;
`endif
    end else begin
      cnt      <= cnt_nxt;
      addr     <= addr_nxt;
      rw       <= rw_nxt;
      shreg    <= shreg_nxt;
      B_ACK    <= ack_nxt;
      B_READY  <= ready_nxt;
      B_BUS_IN <= bus_in_nxt;
      B_SBSY   <= sbsy_nxt;
      S_DVALID <= dvalid_nxt;
      S_DOUT   <= dout_nxt;
`ifdef SLAVE_PARITY_EN
      S_PERR   <= perr_nxt;
`endif
    end
  end

  // Storage; contents survive reset, a write coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (RSTN && mem_we) mem[addr] <= dout_nxt;
  end

endmodule

// File: tb/tb_slave_2k_serial.sv
// Self-checking bench for slave_2k_serial: directed scenarios plus randomized traffic
// against a byte-array memory model with per-cycle expected bus behaviour.
`timescale 1ns/1ps
module tb_slave_2k_serial;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned RD_LAT = 2;
`ifdef SLAVE_PARITY_EN
  localparam int DATA_N = 9;
`else
  localparam int DATA_N = 8;
`endif
  localparam int ACK_C   = ADDR_W;
  localparam int W_DONE  = ADDR_W + 1 + DATA_N;
  localparam int R_FIRST = ADDR_W + 1 + RD_LAT;
  localparam int R_DONE  = R_FIRST + DATA_N;

  localparam int M_NONE = 0;
  localparam int M_SEL  = 1;
  localparam int M_RST  = 2;
  localparam int M_AADD = 3;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       AD_SEL;
  logic       A_ADD;
  logic       B_BUS_OUT;
  logic       B_RW;
  logic       B_ACK;
  logic       B_READY;
  logic       B_BUS_IN;
  logic       B_SBSY;
  logic       S_DVALID;
  logic [7:0] S_DOUT;
  logic       perr_obs;
  logic [13:0] obs;

  int         n_checks;
  int         n_errors;
  logic [7:0] ref_mem [2048];
  bit         ref_ok  [2048];
  logic [10:0] written[$];
  logic [7:0] ref_dout;

`ifdef SLAVE_PARITY_EN
  logic S_PERR;
  assign perr_obs = S_PERR;
`else
  assign perr_obs = 1'b0;
`endif

  assign obs = {B_ACK, B_READY, B_BUS_IN, B_SBSY, S_DVALID, perr_obs, S_DOUT};

  slave_2k_serial #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .AD_SEL    (AD_SEL),
    .A_ADD     (A_ADD),
    .B_BUS_OUT (B_BUS_OUT),
    .B_RW      (B_RW),
    .B_ACK     (B_ACK),
    .B_READY   (B_READY),
    .B_BUS_IN  (B_BUS_IN),
    .B_SBSY    (B_SBSY),
    .S_DVALID  (S_DVALID),
    .S_DOUT    (S_DOUT)
`ifdef SLAVE_PARITY_EN
    ,
    .S_PERR    (S_PERR)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h  {ack,rdy,bit,sbsy,dv,perr,dout}", tag, got, exp);
    end
  endtask

  // Idle cycles with random noise on lines the slave must ignore while A_ADD is low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      AD_SEL    = 1'($urandom);
      A_ADD     = 1'b0;
      B_BUS_OUT = 1'($urandom);
      B_RW      = 1'($urandom);
      RSTN      = 1'b1;
      @(posedge CLK); #1;
      check("idle", 32'(obs), 32'({6'b0, ref_dout}));
    end
  endtask

  // One bus transaction starting in the current cycle (cycle 0 = first address bit).
  // Outputs are compared every cycle 1..done against timing derived from the latency rules.
  task automatic run_txn(input string name, input bit wr, input logic [10:0] a,
                         input logic [7:0] d, input int mode, input int k, input bit bad_par);
    int         last;
    logic [7:0] byte_exp;
    logic [8:0] frame;
    logic [7:0] dout_before;
    bit         killed;
    logic       e_ack, e_rdy, e_bit, e_sbsy, e_dv, e_perr;
    logic [7:0] e_dout;
    last        = wr ? W_DONE : R_DONE;
    byte_exp    = wr ? d : ref_mem[a];
    frame       = {^byte_exp, byte_exp};
    dout_before = ref_dout;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        killed = (mode != M_NONE) && (c > k);
        e_ack = 1'b0; e_rdy = 1'b0; e_bit = 1'b0; e_sbsy = 1'b0; e_dv = 1'b0; e_perr = 1'b0;
        e_dout = (killed && mode == M_RST) ? 8'h00 : dout_before;
        if (!killed) begin
          e_ack  = (c == ACK_C);
          e_sbsy = (c < last);
          if (wr) begin
            if (c == last) begin
              if (bad_par) e_perr = 1'b1;
              else begin e_rdy = 1'b1; e_dv = 1'b1; e_dout = d; end
            end
          end else begin
            if (c >= R_FIRST && c < R_DONE) begin e_rdy = 1'b1; e_bit = frame[c - R_FIRST]; end
            if (c == last) begin e_dv = 1'b1; e_dout = byte_exp; end
          end
        end
        check($sformatf("%s c%0d", name, c), 32'(obs),
              32'({e_ack, e_rdy, e_bit, e_sbsy, e_dv, e_perr, e_dout}));
      end
      if (c < last) begin
        RSTN      = 1'b1;
        AD_SEL    = 1'b1;
        A_ADD     = (c < ADDR_W);
        B_RW      = wr;
        B_BUS_OUT = 1'b0;
        if (c < ADDR_W) B_BUS_OUT = a[c];
        else if (wr && c > ADDR_W && c <= ADDR_W + 8) B_BUS_OUT = d[c - ADDR_W - 1];
        else if (wr && DATA_N == 9 && c == ADDR_W + 9) B_BUS_OUT = (^d) ^ bad_par;
        else B_BUS_OUT = 1'($urandom);
        if (mode == M_NONE && c > ADDR_W) A_ADD = 1'($urandom);
        if (mode == M_SEL && c >= k) AD_SEL = 1'b0;
        if (mode == M_AADD && c >= k) A_ADD = 1'b0;
        if (mode == M_RST && c == k) RSTN = 1'b0;
        if (mode == M_RST && c > k) begin AD_SEL = 1'b0; A_ADD = 1'b0; end
        @(posedge CLK); #1;
      end
    end
    AD_SEL = 1'b0; A_ADD = 1'b0; B_BUS_OUT = 1'b0; RSTN = 1'b1;
    if (mode == M_RST) ref_dout = 8'h00;
    else if (mode == M_NONE && !(wr && bad_par)) begin
      ref_dout = byte_exp;
      if (wr) begin
        ref_mem[a] = d;
        if (!ref_ok[a]) written.push_back(a);
        ref_ok[a] = 1'b1;
      end
    end
  endtask

  initial begin
    bit          wr;
    logic [10:0] a;
    logic [7:0]  d;
    int          mode, k, r, last;
    bit          bp;
    n_checks = 0;
    n_errors = 0;
    ref_dout = 8'h00;
    for (int i = 0; i < 2048; i++) begin ref_ok[i] = 1'b0; ref_mem[i] = 8'h00; end
    RSTN = 1'b0; AD_SEL = 1'b0; A_ADD = 1'b0; B_BUS_OUT = 1'b0; B_RW = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    check("reset", 32'(obs), 32'(0));

    // Basic write then read.
    run_txn("wr_2a5", 1'b1, 11'h2A5, 8'hC3, M_NONE, 0, 1'b0);
    idle(2);
    run_txn("rd_2a5", 1'b0, 11'h2A5, 8'h00, M_NONE, 0, 1'b0);
    idle(1);

    // Address extremes, no aliasing.
    run_txn("wr_7ff", 1'b1, 11'h7FF, 8'h11, M_NONE, 0, 1'b0);
    run_txn("wr_000", 1'b1, 11'h000, 8'h22, M_NONE, 0, 1'b0);
    run_txn("rd_7ff", 1'b0, 11'h7FF, 8'h00, M_NONE, 0, 1'b0);
    run_txn("rd_000", 1'b0, 11'h000, 8'h00, M_NONE, 0, 1'b0);
    idle(2);

    // AD_SEL dropped after data bit 4 of a write: old contents survive.
    run_txn("wr_010", 1'b1, 11'h010, 8'h55, M_NONE, 0, 1'b0);
    idle(1);
    run_txn("ab_010", 1'b1, 11'h010, 8'h9A, M_SEL, ADDR_W + 1 + 5, 1'b0);
    idle(2);
    run_txn("rd_010", 1'b0, 11'h010, 8'h00, M_NONE, 0, 1'b0);
    idle(1);

    // A_ADD dropped during the address phase: no B_ACK.
    run_txn("aadd", 1'b1, 11'h010, 8'hEE, M_AADD, 5, 1'b0);
    idle(1);
    run_txn("rd_010b", 1'b0, 11'h010, 8'h00, M_NONE, 0, 1'b0);

    // Back-to-back read then write, then verify.
    run_txn("wr_100", 1'b1, 11'h100, 8'h3C, M_NONE, 0, 1'b0);
    idle(1);
    run_txn("b2b_rd", 1'b0, 11'h100, 8'h00, M_NONE, 0, 1'b0);
    run_txn("b2b_wr", 1'b1, 11'h101, 8'hA0, M_NONE, 0, 1'b0);
    run_txn("rd_101", 1'b0, 11'h101, 8'h00, M_NONE, 0, 1'b0);
    idle(1);

    // Reset during read bit 3, then the data is still intact.
    run_txn("rst_rd", 1'b0, 11'h2A5, 8'h00, M_RST, R_FIRST + 3, 1'b0);
    idle(2);
    run_txn("rd_2a5b", 1'b0, 11'h2A5, 8'h00, M_NONE, 0, 1'b0);
    idle(1);

`ifdef SLAVE_PARITY_EN
    // Bad parity write is rejected with S_PERR.
    run_txn("wr_00f", 1'b1, 11'h00F, 8'h33, M_NONE, 0, 1'b0);
    idle(1);
    run_txn("perr", 1'b1, 11'h00F, 8'h0F, M_NONE, 0, 1'b1);
    idle(1);
    run_txn("rd_00f", 1'b0, 11'h00F, 8'h00, M_NONE, 0, 1'b0);
    idle(1);
`endif

    // Randomized traffic with occasional aborts and resets.
    for (int i = 0; i < 60; i++) begin
      wr = (written.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) a = 11'($urandom_range(0, 2047));
      else    a = written[$urandom_range(0, written.size() - 1)];
      d    = 8'($urandom);
      r    = int'($urandom_range(0, 11));
      mode = M_NONE;
      k    = 0;
      bp   = 1'b0;
      last = wr ? W_DONE : R_DONE;
      if (r == 9)       begin mode = M_SEL;  k = int'($urandom_range(1, last - 1)); end
      else if (r == 10) begin mode = M_AADD; k = int'($urandom_range(1, ADDR_W - 1)); end
      else if (r == 11) begin mode = M_RST;  k = int'($urandom_range(1, last - 1)); end
`ifdef SLAVE_PARITY_EN
      if (wr && mode == M_NONE && $urandom_range(0, 5) == 0) bp = 1'b1;
`endif
      run_txn($sformatf("rnd%0d", i), wr, a, d, mode, k, bp);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
